// File: rtl/uart_rx_param.sv
// Parametrised asynchronous serial receiver: oversampled 3-sample majority vote,
// false-start rejection, parity/framing checks and an idle-gap packet delimiter.
module uart_rx_param #(
    parameter int CLK_FREQ   = 24000000,
    parameter int BAUD       = 57600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int GAP_BITS   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 idle,
    output logic                 end_of_packet
);

    localparam int DIV     = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCNT_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_BITS);
    localparam int GAP_MAX = GAP_BITS * OVERSAMPLE;
    // Gap counter is sized so that its saturation value always fits.
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    localparam logic [SCNT_W-1:0] S_FIRST  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] S_MID    = SCNT_W'(OVERSAMPLE / 2);
    localparam logic [SCNT_W-1:0] S_RES    = SCNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SCNT_W-1:0] S_END    = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);
    localparam logic [GAP_W-1:0]  GAP_FULL = GAP_W'(GAP_MAX);
    localparam logic [GAP_W-1:0]  GAP_PRE  = GAP_W'(GAP_MAX - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_param: CLK_FREQ too low for BAUD*OVERSAMPLE");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_param: OVERSAMPLE must be even and within 8..32");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_rx_param: DATA_BITS must be within 5..9");
    end
    if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
        $error("uart_rx_param: PARITY must be 0..2 and STOP_BITS 1..2");
    end
    if (GAP_BITS < 1 || GAP_BITS > 15) begin : g_bad_gap
        $error("uart_rx_param: GAP_BITS must be within 1..15");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    logic [DIV_W-1:0]     div_q;
    logic                 tick;
    logic [1:0]           sync_q;
    logic                 rxd_s;
    state_e               state_q;
    logic [SCNT_W-1:0]    scnt_q;
    logic [1:0]           samp_q;
    logic                 maj;
    logic [BIT_W-1:0]     bit_q;
    logic                 stop_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_bit_q;
    logic                 exp_par;
    logic                 ferr_acc_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic [GAP_W-1:0]     gap_q;
    logic                 eop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxd_s   = sync_q[1];
    // Third sample is the live synchronised value at the resolve point.
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);
    assign exp_par = (PARITY == 2) ? ~(^shreg_q) : (^shreg_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            scnt_q     <= '0;
            samp_q     <= 2'b11;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            // NOTE: the strobe defaults low every clk; only the final-stop branch raises it.
            valid_q <= 1'b0;
            if (tick) begin
                if (state_q == ST_IDLE) begin
                    if (!rxd_s) begin
                        state_q    <= ST_START;
                        scnt_q     <= '0;
                        ferr_acc_q <= 1'b0;
                    end
                end else begin
                    scnt_q <= (scnt_q == S_END) ? '0 : scnt_q + 1'b1;
                    if (scnt_q == S_FIRST) samp_q[0] <= rxd_s;
                    if (scnt_q == S_MID)   samp_q[1] <= rxd_s;
                    case (state_q)
                        ST_START: begin
                            if (scnt_q == S_RES && maj) begin
                                state_q <= ST_IDLE;
                            end else if (scnt_q == S_END) begin
                                state_q <= ST_DATA;
                                bit_q   <= '0;
                            end
                        end
                        ST_DATA: begin
                            if (scnt_q == S_RES) shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
                            if (scnt_q == S_END) begin
                                if (bit_q == BIT_LAST) begin
                                    state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                                    stop_q  <= 1'b0;
                                end else begin
                                    bit_q <= bit_q + 1'b1;
                                end
                            end
                        end
                        ST_PARITY: begin
                            if (scnt_q == S_RES) par_bit_q <= maj;
                            if (scnt_q == S_END) begin
                                state_q <= ST_STOP;
                                stop_q  <= 1'b0;
                            end
                        end
                        ST_STOP: begin
                            if (scnt_q == S_RES) begin
                                if (stop_q == STOP_LAST) begin
                                    // Leave mid-bit so a back-to-back start edge is caught.
                                    state_q <= ST_IDLE;
                                    data_q  <= shreg_q;
                                    perr_q  <= (PARITY != 0) && (par_bit_q != exp_par);
                                    ferr_q  <= ferr_acc_q | ~maj;
                                    valid_q <= 1'b1;
                                end else if (!maj) begin
                                    ferr_acc_q <= 1'b1;
                                end
                            end else if (scnt_q == S_END) begin
                                stop_q <= 1'b1;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= GAP_FULL;
            eop_q <= 1'b0;
        end else begin
            eop_q <= 1'b0;
            if (state_q != ST_IDLE) begin
                gap_q <= '0;
            end else if (tick && gap_q != GAP_FULL) begin
                gap_q <= gap_q + 1'b1;
                eop_q <= (gap_q == GAP_PRE);
            end
        end
    end

    assign data          = data_q;
    assign data_valid    = valid_q;
    assign parity_err    = perr_q;
    assign frame_err     = ferr_q;
    assign idle          = (gap_q == GAP_FULL);
    assign end_of_packet = eop_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three receivers (8N1, 8E1, 7O2) share clk/rst_n,
// each driven on its own line; expected words are queued as frames are sent.
module tb_uart_rx_param;

    localparam int CLK_FREQ = 6400000;
    localparam int BAUD     = 100000;
    localparam int OS       = 16;
    localparam int BIT_CLK  = 64;
    localparam int CH_A     = 0;
    localparam int CH_B     = 1;
    localparam int CH_C     = 2;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd_a = 1'b1;
    logic       rxd_b = 1'b1;
    logic       rxd_c = 1'b1;
    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic       dv_a, pe_a, fe_a, idle_a, eop_a;
    logic       dv_b, pe_b, fe_b, idle_b, eop_b;
    logic       dv_c, pe_c, fe_c, idle_c, eop_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   dv_cnt_a = 0, dv_cnt_b = 0, dv_cnt_c = 0;
    int   eop_cnt_a = 0;
    int   last_dv_cyc_a = 0, last_eop_cyc_a = 0;

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .GAP_BITS(2)) u_a (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .data(data_a), .data_valid(dv_a),
        .parity_err(pe_a), .frame_err(fe_a), .idle(idle_a), .end_of_packet(eop_a));

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                    .PARITY(1), .STOP_BITS(1), .GAP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .data(data_b), .data_valid(dv_b),
        .parity_err(pe_b), .frame_err(fe_b), .idle(idle_b), .end_of_packet(eop_b));

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(7),
                    .PARITY(2), .STOP_BITS(2), .GAP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_c), .data(data_c), .data_valid(dv_c),
        .parity_err(pe_c), .frame_err(fe_c), .idle(idle_c), .end_of_packet(eop_c));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic score(input string ch, input exp_t e, input logic [8:0] d,
                         input logic pe, input logic fe);
        check({ch, "_data"}, 32'(d), 32'(e.d));
        check({ch, "_parity_err"}, 32'(pe), 32'(e.pe));
        check({ch, "_frame_err"}, 32'(fe), 32'(e.fe));
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (eop_a) begin
                eop_cnt_a++;
                last_eop_cyc_a = cyc;
            end
            if (dv_a) begin
                dv_cnt_a++;
                last_dv_cyc_a = cyc;
                if (q_a.size() == 0) check("a_unexpected_valid", 32'(dv_a), 32'd0);
                else begin
                    e = q_a.pop_front();
                    score("a", e, {1'b0, data_a}, pe_a, fe_a);
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (dv_b) begin
                dv_cnt_b++;
                if (q_b.size() == 0) check("b_unexpected_valid", 32'(dv_b), 32'd0);
                else begin
                    e = q_b.pop_front();
                    score("b", e, {1'b0, data_b}, pe_b, fe_b);
                end
            end
        end
    end

    initial begin : mon_c
        exp_t e;
        forever begin
            @(negedge clk);
            if (dv_c) begin
                dv_cnt_c++;
                if (q_c.size() == 0) check("c_unexpected_valid", 32'(dv_c), 32'd0);
                else begin
                    e = q_c.pop_front();
                    score("c", e, {2'b0, data_c}, pe_c, fe_c);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "tb_uart_rx_param timeout");
    end

    task automatic set_rxd(input int ch, input logic v);
        case (ch)
            CH_A:    rxd_a = v;
            CH_B:    rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    function automatic int qsize(input int ch);
        case (ch)
            CH_A:    return q_a.size();
            CH_B:    return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    // Drives one frame LSB first; call at a negedge.
    task automatic send_frame(input int ch, input logic [8:0] d, input int dbits,
                              input int pmode, input logic pbit, input int nstop,
                              input logic [1:0] stops);
        logic [15:0] f;
        int          n;
        f = '0;
        n = 0;
        f[n] = 1'b0;
        n++;
        for (int i = 0; i < dbits; i++) begin
            f[n] = d[i];
            n++;
        end
        if (pmode != 0) begin
            f[n] = pbit;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            f[n] = stops[i];
            n++;
        end
        for (int i = 0; i < n; i++) begin
            set_rxd(ch, f[i]);
            repeat (BIT_CLK) @(negedge clk);
        end
        set_rxd(ch, 1'b1);
    endtask

    function automatic logic exp_perr(input logic [8:0] d, input int dbits,
                                      input int pmode, input logic pbit);
        logic x;
        x = 1'b0;
        for (int i = 0; i < dbits; i++) x = x ^ d[i];
        if (pmode == 0) return 1'b0;
        return (pmode == 1) ? (pbit != x) : (pbit != ~x);
    endfunction

    task automatic xmit(input int ch, input logic [8:0] d, input int dbits, input int pmode,
                        input logic pbit, input int nstop, input logic [1:0] stops);
        exp_t e;
        e.d  = d;
        e.pe = exp_perr(d, dbits, pmode, pbit);
        e.fe = (nstop == 1) ? ~stops[0] : ~(stops[0] & stops[1]);
        case (ch)
            CH_A:    q_a.push_back(e);
            CH_B:    q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
        send_frame(ch, d, dbits, pmode, pbit, nstop, stops);
    endtask

    task automatic wait_drain(input int ch, input int budget, input string tag);
        int n;
        n = 0;
        while (qsize(ch) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(qsize(ch)), 32'd0);
    endtask

    initial begin : stim
        int t0;
        int n;
        int e0;
        int d0;

        repeat (5) @(negedge clk);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_valid", 32'(dv_a), 32'd0);
        check("rst_parity_err", 32'(pe_b), 32'd0);
        check("rst_frame_err", 32'(fe_c), 32'd0);
        check("rst_eop", 32'(eop_a), 32'd0);
        check("rst_idle", 32'({idle_a, idle_b, idle_c}), 32'd7);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("no_eop_after_reset", 32'(eop_cnt_a), 32'd0);

        // 8N1 0xA5 with start-to-valid latency
        t0 = cyc;
        xmit(CH_A, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
        wait_drain(CH_A, 200, "a5_drain");
        check("a5_latency_in_window",
              32'((last_dv_cyc_a - t0 >= 616) && (last_dv_cyc_a - t0 <= 626)), 32'd1);
        repeat (200) @(negedge clk);
        check("a5_single_valid", 32'(dv_cnt_a), 32'd1);

        // 8E1: wrong parity bit then correct one
        xmit(CH_B, 9'h003, 8, 1, 1'b1, 1, 2'b11);
        xmit(CH_B, 9'h003, 8, 1, 1'b0, 1, 2'b11);
        wait_drain(CH_B, 200, "b_drain");
        repeat (100) @(negedge clk);
        check("b_valid_count", 32'(dv_cnt_b), 32'd2);

        // 7O2: second stop low, then a clean frame
        xmit(CH_C, 9'h055, 7, 2, 1'b1, 2, 2'b01);
        repeat (200) @(negedge clk);
        xmit(CH_C, 9'h02A, 7, 2, 1'b0, 2, 2'b11);
        wait_drain(CH_C, 200, "c_drain");
        repeat (100) @(negedge clk);
        check("c_valid_count", 32'(dv_cnt_c), 32'd2);

        // 12-clk glitch on an idle line must be rejected
        d0 = dv_cnt_a;
        rxd_a = 1'b0;
        repeat (12) @(negedge clk);
        rxd_a = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_no_valid", 32'(dv_cnt_a - d0), 32'd0);
        check("glitch_idle_back", 32'(idle_a), 32'd1);

        // back-to-back frames then one end_of_packet
        e0 = eop_cnt_a;
        xmit(CH_A, 9'h011, 8, 0, 1'b0, 1, 2'b11);
        xmit(CH_A, 9'h022, 8, 0, 1'b0, 1, 2'b11);
        xmit(CH_A, 9'h033, 8, 0, 1'b0, 1, 2'b11);
        wait_drain(CH_A, 200, "b2b_drain");
        n = 0;
        while (eop_cnt_a == e0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("b2b_eop_seen", 32'(eop_cnt_a - e0), 32'd1);
        check("b2b_eop_delay_in_window",
              32'((last_eop_cyc_a - last_dv_cyc_a >= 124) &&
                  (last_eop_cyc_a - last_dv_cyc_a <= 132)), 32'd1);
        repeat (200) @(negedge clk);
        check("b2b_single_eop", 32'(eop_cnt_a - e0), 32'd1);
        check("b2b_idle_after", 32'(idle_a), 32'd1);
        check("b2b_valid_count", 32'(dv_cnt_a - d0), 32'd3);

        // reset during bit 4 of 0xF0, then a clean 0x0F
        e0 = eop_cnt_a;
        d0 = dv_cnt_a;
        fork
            send_frame(CH_A, 9'h0F0, 8, 0, 1'b0, 1, 2'b11);
            begin
                repeat (5 * BIT_CLK + 20) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("mid_rst_data", 32'(data_a), 32'd0);
                check("mid_rst_flags", 32'({dv_a, pe_a, fe_a, eop_a}), 32'd0);
                check("mid_rst_idle", 32'(idle_a), 32'd1);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (200) @(negedge clk);
        check("mid_rst_no_valid", 32'(dv_cnt_a - d0), 32'd0);
        check("mid_rst_no_eop", 32'(eop_cnt_a - e0), 32'd0);
        check("mid_rst_data_held", 32'(data_a), 32'd0);
        xmit(CH_A, 9'h00F, 8, 0, 1'b0, 1, 2'b11);
        wait_drain(CH_A, 200, "post_rst_drain");
        repeat (100) @(negedge clk);
        check("post_rst_valid_count", 32'(dv_cnt_a - d0), 32'd1);

        check("final_queues_empty", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
